// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - sequential radix-2 shift-add WIDTH x WIDTH multiplier
//
// Purpose: multiplies two WIDTH-bit operands, unsigned or two's complement,
// one partial product per clock, with valid/ready handshakes on both sides.
// Optional build macro: MUL_EARLY_TERM_EN ends the RUN phase as soon as the
// remaining multiplier bits are all zero (results identical, latency shorter).
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     operand pair presented
//   in_ready     block is idle and accepts an operand pair
//   a, b         multiplicand / multiplier (WIDTH bits)
//   signed_mode  1 = operands are two's complement, sampled with the operands
//   out_valid    product is valid
//   out_ready    consumer accepts the product
//   product      2*WIDTH-bit result
//   busy         high while an operation is running or waiting to be taken
module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 neg;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mplier_next;
    logic [2*WIDTH-1:0]   result;
    logic                 last;

    // Magnitudes are taken modulo 2^WIDTH, so the most negative value maps
    // to 2^(WIDTH-1), which is exactly its magnitude as an unsigned number.
    always_comb begin
        a_mag       = (signed_mode && a[WIDTH-1]) ? -a : a;
        b_mag       = (signed_mode && b[WIDTH-1]) ? -b : b;
        partial     = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
        acc_next    = acc + partial;
        mplier_next = mplier >> 1;
        result      = neg ? -acc_next : acc_next;
`ifdef MUL_EARLY_TERM_EN
        // A zero magnitude of b still takes one RUN cycle: mplier_next is zero
        // on the first cycle, so this terminates there.
        last        = (cnt == LAST) || (mplier_next == '0);
`else
        last        = (cnt == LAST);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            product   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a_mag;
                        mplier   <= b_mag;
                        neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier_next;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        product   <= result;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
Parametrised sequential successor to the 4x4 combinational array multiplier. Computes a WIDTH x WIDTH product with a radix-2 shift-add datapath. Supports a per-operation unsigned or two's-complement mode. Uses valid/ready handshakes on input and output, so it can sit between the pin-level wrapper and any downstream consumer that can stall.

Parameters:
WIDTH, 4, operand width in bits (legal range 2..16); product is 2*WIDTH bits.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand pair is presented.
in_ready  output  1  block can accept an operand pair.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
signed_mode  input  1  1 = a and b are two's complement; 0 = unsigned. Sampled with the operands.
out_valid  output  1  product is valid.
out_ready  input  1  consumer accepts the product.
product  output  2*WIDTH  result; two's complement when signed_mode was 1.
busy  output  1  high in the RUN and DONE states.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset (async assert, any state):
  - state goes to IDLE.
  - product, accumulator, shift registers, counter and sign flag clear to 0.
  - out_valid=0, busy=0.
  - in_ready=1 (in_ready is decoded from state==IDLE).
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at an edge, the operands are accepted:
    - mcand <= |a| and mplier <= |b| (magnitude only when signed_mode=1; otherwise raw). The magnitude of the most negative value is 2^(WIDTH-1), held as unsigned WIDTH bits.
    - neg <= signed_mode & (a[MSB] ^ b[MSB]).
    - acc <= 0, cnt <= 0, state <= RUN.
  - in_valid=0: stay in IDLE.
- RUN (in_ready=0, out_valid=0):
  - Each cycle: if mplier[0]==1, acc <= acc + (mcand << cnt). Then mplier >>= 1 and cnt++.
  - Width rule: acc is 2*WIDTH bits and the addition never overflows.
  - On the cycle with cnt==WIDTH-1, state <= DONE and product <= neg ? -(acc_next) : acc_next, where acc_next is the value written this cycle.
  - Exactly WIDTH RUN cycles.
  - Latency: operand accept at edge T gives out_valid=1 after edge T+WIDTH.
- DONE:
  - out_valid=1; product and busy are held stable.
  - out_ready=1 at an edge: state <= IDLE, out_valid drops after that edge.
  - out_ready=0: hold indefinitely (backpressure). Inputs are ignored.
- No back-to-back overlap. Sustained throughput is one product per WIDTH+2 cycles when out_ready is held high.
- in_valid and out_ready are don't-care outside IDLE and DONE respectively.
- Operands, signed_mode and in_valid are ignored while in_ready=0. They need not be held after acceptance.
- Reset mid-operation (RUN or DONE) aborts the operation. No out_valid pulse is produced, and the next accepted operands start cleanly.
- Signed range: -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2), which is representable. Every result fits in 2*WIDTH bits, so there is no overflow flag.

Optional Feature:
Macro: MUL_EARLY_TERM_EN.
- Defined:
  - In RUN, if mplier_next (after the shift) is all-zero, go to DONE immediately and compute product from acc_next.
  - In IDLE, if the accepted magnitude of b is 0, still take exactly one RUN cycle.
  - RUN length = max(1, position of highest set bit of |b| + 1).
- Undefined: fixed WIDTH-cycle RUN as specified above. The early-termination logic is not synthesised.
- Results are identical in both builds; only latency differs.

Test Plan:
1. WIDTH=4, unsigned, a=15, b=15, out_ready=1 -> product=0xE1 (225); out_valid exactly 4 cycles after the accept edge; in_ready low during RUN/DONE.
2. WIDTH=4, signed: a=-8, b=-8 -> 0x40; a=-3, b=5 -> 0xF1 (-15); a=7, b=-1 -> 0xF9 (-7); a=0, b=-8 -> 0x00.
3. Backpressure: out_ready=0 for 10 cycles in DONE -> product and out_valid held, new in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
4. Reset mid-RUN: assert rst 2 cycles after accept (async, between edges) -> in_ready=1, out_valid=0 and product=0 immediately; a following a=3, b=4 -> 0x0C with nominal latency.
5. MUL_EARLY_TERM_EN defined, WIDTH=4: b=1 -> latency 1; b=0 -> latency 1 with product 0; b=8 -> latency 4; b=-1 signed -> latency 1 (|b|=1).
6. WIDTH=8: exhaustive unsigned and signed sweep against a reference model -> all 65536 products match in both modes; latency 8 without the macro.
